// File: rtl/mem_pipe.sv
// Single-port word memory behind a valid/ready request/response handshake.
// One request in flight; byte/half/word access with alignment and range checking.

package mem_pipe_pkg;
    typedef enum logic [1:0] {
        MEM_DT_BYTE = 2'd0,
        MEM_DT_HALF = 2'd1,
        MEM_DT_WORD = 2'd2
    } mem_dt_e;
endpackage

module mem_pipe
    import mem_pipe_pkg::*;
#(
    parameter int unsigned N    = 64,
    parameter int unsigned WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wd,
    input  logic        req_we,
    input  mem_dt_e     req_dt,
    input  logic        req_sign,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rd,
    output logic        rsp_err_align,
    output logic        rsp_err_range
);

    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StAcc, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic        we_q, we_d;
    logic [1:0]  dt_q, dt_d;
    logic        sign_q, sign_d;
    logic [31:0] rd_q, rd_d;
    logic        err_align_q, err_align_d;
    logic        err_range_q, err_range_d;

    logic [31:0] mem_q [N];

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          err_align_c;
    logic          err_range_c;
    logic          access_ok;
    logic [31:0]   mem_word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   rd_ext;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic          mem_we;

    // Decode of the latched request: errors, lane enables and read extraction.
    always_comb begin
        idx         = addr_q[AW+1:2];
        lane        = addr_q[1:0];
        err_range_c = {2'b00, addr_q[31:2]} >= 32'(N);
        access_ok   = 1'b0;
        mem_word    = mem_q[idx];
        wr_be       = 4'b0000;
        wr_data     = wd_q;
        rd_ext      = 32'h0;
        byte_sel    = 8'h0;
        half_sel    = addr_q[1] ? mem_word[31:16] : mem_word[15:0];

        unique case (lane)
            2'd0: byte_sel = mem_word[7:0];
            2'd1: byte_sel = mem_word[15:8];
            2'd2: byte_sel = mem_word[23:16];
            2'd3: byte_sel = mem_word[31:24];
            default: byte_sel = 8'h0;
        endcase

        case (dt_q)
            MEM_DT_BYTE: begin
                err_align_c = 1'b0;
                wr_be       = 4'b0001 << lane;
                wr_data     = {4{wd_q[7:0]}};
                rd_ext      = {{24{sign_q & byte_sel[7]}}, byte_sel};
            end
            MEM_DT_HALF: begin
                err_align_c = addr_q[0];
                wr_be       = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_data     = {2{wd_q[15:0]}};
                rd_ext      = {{16{sign_q & half_sel[15]}}, half_sel};
            end
            MEM_DT_WORD: begin
                err_align_c = |addr_q[1:0];
                wr_be       = 4'b1111;
                rd_ext      = mem_word;
            end
            default: err_align_c = 1'b1;
        endcase

        access_ok = !err_align_c && !err_range_c;
        mem_we    = (state_q == StAcc) && (cnt_q == 4'd0) && we_q && access_ok;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wd_d        = wd_q;
        we_d        = we_q;
        dt_d        = dt_q;
        sign_d      = sign_q;
        rd_d        = rd_q;
        err_align_d = err_align_q;
        err_range_d = err_range_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wd_d    = req_wd;
                    we_d    = req_we;
                    dt_d    = req_dt;
                    sign_d  = req_sign;
                    cnt_d   = 4'(WAIT);
                    state_d = StAcc;
                end
            end
            StAcc: begin
                if (cnt_q == 4'd0) begin
                    rd_d        = (access_ok && !we_q) ? rd_ext : 32'h0;
                    err_align_d = err_align_c;
                    err_range_d = err_range_c;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            addr_q      <= 32'h0;
            wd_q        <= 32'h0;
            we_q        <= 1'b0;
            dt_q        <= 2'd0;
            sign_q      <= 1'b0;
            rd_q        <= 32'h0;
            err_align_q <= 1'b0;
            err_range_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wd_q        <= wd_d;
            we_q        <= we_d;
            dt_q        <= dt_d;
            sign_q      <= sign_d;
            rd_q        <= rd_d;
            err_align_q <= err_align_d;
            err_range_q <= err_range_d;
        end
    end

    // Contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem_q[idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign req_ready     = (state_q == StIdle);
    assign rsp_valid     = (state_q == StResp);
    assign rsp_rd        = rd_q;
    assign rsp_err_align = err_align_q;
    assign rsp_err_range = err_range_q;

endmodule

// File: tb/tb_mem_pipe.sv
// Scoreboard bench for mem_pipe: two instances (WAIT=0 and WAIT=3) driven by directed
// vectors; expected responses are queued at issue and checked by per-instance monitors.

module tb_mem_pipe;
    import mem_pipe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst           [2];
    logic        req_valid     [2];
    logic        req_ready     [2];
    logic [31:0] req_addr      [2];
    logic [31:0] req_wd        [2];
    logic        req_we        [2];
    mem_dt_e     req_dt        [2];
    logic        req_sign      [2];
    logic        rsp_valid     [2];
    logic        rsp_ready     [2];
    logic [31:0] rsp_rd        [2];
    logic        rsp_err_align [2];
    logic        rsp_err_range [2];

    mem_pipe #(.N(64), .WAIT(0)) u_dut0 (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .req_wd(req_wd[0]), .req_we(req_we[0]), .req_dt(req_dt[0]), .req_sign(req_sign[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rd(rsp_rd[0]),
        .rsp_err_align(rsp_err_align[0]), .rsp_err_range(rsp_err_range[0])
    );

    mem_pipe #(.N(64), .WAIT(3)) u_dut3 (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .req_wd(req_wd[1]), .req_we(req_we[1]), .req_dt(req_dt[1]), .req_sign(req_sign[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rd(rsp_rd[1]),
        .rsp_err_align(rsp_err_align[1]), .rsp_err_range(rsp_err_range[1])
    );

    typedef struct packed {
        logic [31:0] rd;
        logic        ea;
        logic        er;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    exp_t mon_e0, mon_e1;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got no/unexpected response, want scoreboard match", name);
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    always @(negedge clk) begin
        if (rsp_valid[0] && rsp_ready[0]) begin
            if (exp_q0.size() == 0) begin
                fail("dut0 unexpected response");
            end else begin
                mon_e0 = exp_q0.pop_front();
                check32("dut0 rsp_rd", rsp_rd[0], mon_e0.rd);
                check32("dut0 err_align", 32'(rsp_err_align[0]), 32'(mon_e0.ea));
                check32("dut0 err_range", 32'(rsp_err_range[0]), 32'(mon_e0.er));
            end
        end
    end

    always @(negedge clk) begin
        if (rsp_valid[1] && rsp_ready[1]) begin
            if (exp_q1.size() == 0) begin
                fail("dut3 unexpected response");
            end else begin
                mon_e1 = exp_q1.pop_front();
                check32("dut3 rsp_rd", rsp_rd[1], mon_e1.rd);
                check32("dut3 err_align", 32'(rsp_err_align[1]), 32'(mon_e1.ea));
                check32("dut3 err_range", 32'(rsp_err_range[1]), 32'(mon_e1.er));
            end
        end
    end

    // One full transaction; stall holds rsp_ready low for that many cycles after rsp_valid rises.
    task automatic issue(input int k, input string name, input logic [31:0] addr,
                         input logic [31:0] wd, input logic we, input mem_dt_e dt,
                         input logic sgn, input logic [31:0] xrd, input logic xea,
                         input logic xer, input int stall);
        exp_t e;
        int   n;
        e = {xrd, xea, xer};
        if (k == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        rsp_ready[k] = (stall == 0);
        @(negedge clk);
        req_addr[k]  = addr;
        req_wd[k]    = wd;
        req_we[k]    = we;
        req_dt[k]    = dt;
        req_sign[k]  = sgn;
        req_valid[k] = 1'b1;
        n = 0;
        while (!req_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail({name, " req_ready timeout"});
        @(posedge clk);
        #1;
        // Scramble request fields while busy; they must be ignored.
        req_valid[k] = 1'b0;
        req_addr[k]  = $urandom;
        req_wd[k]    = $urandom;
        req_we[k]    = ~we;
        req_sign[k]  = ~sgn;
        req_dt[k]    = MEM_DT_BYTE;
        n = 0;
        while (!rsp_valid[k] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check32({name, " latency"}, 32'(n), (k == 0) ? 32'd1 : 32'd4);
        for (int i = 0; i < stall; i++) begin
            check32({name, " stall valid"}, 32'(rsp_valid[k]), 32'd1);
            check32({name, " stall rd"}, rsp_rd[k], xrd);
            check32({name, " stall req_ready"}, 32'(req_ready[k]), 32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready[k] = 1'b1;
        n = 0;
        while (qsize(k) != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (qsize(k) != 0) begin
            fail({name, " response timeout"});
            if (k == 0) void'(exp_q0.pop_front());
            else        void'(exp_q1.pop_front());
        end else begin
            check32({name, " req_ready after hs"}, 32'(req_ready[k]), 32'd1);
            check32({name, " rsp_valid after hs"}, 32'(rsp_valid[k]), 32'd0);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k]       = 1'b1;
            req_valid[k] = 1'b0;
            req_addr[k]  = 32'h0;
            req_wd[k]    = 32'h0;
            req_we[k]    = 1'b0;
            req_dt[k]    = MEM_DT_WORD;
            req_sign[k]  = 1'b0;
            rsp_ready[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check32("reset rsp_valid", 32'(rsp_valid[k]), 32'd0);
            check32("reset rsp_rd", rsp_rd[k], 32'h0);
            check32("reset err_align", 32'(rsp_err_align[k]), 32'd0);
            check32("reset err_range", 32'(rsp_err_range[k]), 32'd0);
            rst[k] = 1'b0;
        end
        #1;
        check32("post-reset req_ready0", 32'(req_ready[0]), 32'd1);
        check32("post-reset req_ready3", 32'(req_ready[1]), 32'd1);

        // WAIT=0: sign/zero extension and lane merging
        issue(0, "w10",     32'h10, 32'h8000_00F1, 1, MEM_DT_WORD, 0, 32'h0, 0, 0, 0);
        issue(0, "rb10 s1", 32'h10, 32'h0, 0, MEM_DT_BYTE, 1, 32'hFFFF_FFF1, 0, 0, 0);
        issue(0, "rb10 s0", 32'h10, 32'h0, 0, MEM_DT_BYTE, 0, 32'h0000_00F1, 0, 0, 0);
        issue(0, "w14",     32'h14, 32'h1122_3344, 1, MEM_DT_WORD, 0, 32'h0, 0, 0, 0);
        issue(0, "wh16",    32'h16, 32'hDEAD_BEEF, 1, MEM_DT_HALF, 0, 32'h0, 0, 0, 0);
        issue(0, "rw14",    32'h14, 32'h0, 0, MEM_DT_WORD, 0, 32'hBEEF_3344, 0, 0, 0);
        issue(0, "rh16 s0", 32'h16, 32'h0, 0, MEM_DT_HALF, 0, 32'h0000_BEEF, 0, 0, 0);
        issue(0, "rh16 s1", 32'h16, 32'h0, 0, MEM_DT_HALF, 1, 32'hFFFF_BEEF, 0, 0, 0);
        issue(0, "rh14 s1", 32'h14, 32'h0, 0, MEM_DT_HALF, 1, 32'h0000_3344, 0, 0, 0);
        issue(0, "rb16 s0", 32'h16, 32'h0, 0, MEM_DT_BYTE, 0, 32'h0000_00EF, 0, 0, 0);
        issue(0, "wb13",    32'h13, 32'h1234_56A5, 1, MEM_DT_BYTE, 0, 32'h0, 0, 0, 0);
        issue(0, "rw10 s1", 32'h10, 32'h0, 0, MEM_DT_WORD, 1, 32'hA500_00F1, 0, 0, 0);
        issue(0, "rb13 s1", 32'h13, 32'h0, 0, MEM_DT_BYTE, 1, 32'hFFFF_FFA5, 0, 0, 0);
        issue(0, "rb11 s1", 32'h11, 32'h0, 0, MEM_DT_BYTE, 1, 32'h0000_0000, 0, 0, 0);
        issue(0, "rh12 s0", 32'h12, 32'h0, 0, MEM_DT_HALF, 0, 32'h0000_A500, 0, 0, 0);
        issue(0, "rh12 s1", 32'h12, 32'h0, 0, MEM_DT_HALF, 1, 32'hFFFF_A500, 0, 0, 0);

        // Error handling: misaligned, out of range, illegal size, both at once
        issue(0, "w20",     32'h20, 32'h1234_5678, 1, MEM_DT_WORD, 0, 32'h0, 0, 0, 0);
        issue(0, "w22 mis", 32'h22, 32'hFFFF_FFFF, 1, MEM_DT_WORD, 0, 32'h0, 1, 0, 0);
        issue(0, "rw20",    32'h20, 32'h0, 0, MEM_DT_WORD, 0, 32'h1234_5678, 0, 0, 0);
        issue(0, "rw22 mis", 32'h22, 32'h0, 0, MEM_DT_WORD, 0, 32'h0, 1, 0, 0);
        issue(0, "w00",     32'h00, 32'hCAFE_F00D, 1, MEM_DT_WORD, 0, 32'h0, 0, 0, 0);
        issue(0, "w100 rng", 32'h100, 32'hDEAD_0000, 1, MEM_DT_WORD, 0, 32'h0, 0, 1, 0);
        issue(0, "rw00",    32'h00, 32'h0, 0, MEM_DT_WORD, 0, 32'hCAFE_F00D, 0, 0, 0);
        issue(0, "r dt3",   32'h20, 32'h0, 0, mem_dt_e'(2'd3), 0, 32'h0, 1, 0, 0);
        issue(0, "rh101 both", 32'h101, 32'h0, 0, MEM_DT_HALF, 0, 32'h0, 1, 1, 0);

        // WAIT=3: latency, response stall, abort by reset
        issue(1, "d3 w08",  32'h08, 32'h5555_5555, 1, MEM_DT_WORD, 0, 32'h0, 0, 0, 0);
        issue(1, "d3 rw08 stall", 32'h08, 32'h0, 0, MEM_DT_WORD, 0, 32'h5555_5555, 0, 0, 5);

        @(negedge clk);
        req_addr[1]  = 32'h08;
        req_wd[1]    = 32'hAAAA_AAAA;
        req_we[1]    = 1'b1;
        req_dt[1]    = MEM_DT_WORD;
        req_sign[1]  = 1'b0;
        req_valid[1] = 1'b1;
        check32("abort req_ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst[1] = 1'b1;
        #1;
        check32("abort rsp_valid", 32'(rsp_valid[1]), 32'd0);
        check32("abort rsp_rd", rsp_rd[1], 32'h0);
        check32("abort err_align", 32'(rsp_err_align[1]), 32'd0);
        check32("abort err_range", 32'(rsp_err_range[1]), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        rst[1] = 1'b0;
        #1;
        check32("abort req_ready post", 32'(req_ready[1]), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check32("abort no response", 32'(rsp_valid[1]), 32'd0);
        end
        issue(1, "d3 rw08 post-abort", 32'h08, 32'h0, 0, MEM_DT_WORD, 0, 32'h5555_5555, 0, 0, 0);

        repeat (3) @(posedge clk);
        check32("scoreboard0 drained", 32'(exp_q0.size()), 32'd0);
        check32("scoreboard3 drained", 32'(exp_q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_pipe.md
MEM_PIPE -- requirements
Module: mem_pipe

Interface
REQ-001 The block SHALL have parameter N, default 64, meaning the depth in 32-bit words.
REQ-002 The block SHALL have parameter WAIT, default 0, meaning the number of extra wait cycles per access, in the range 0..15.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, SHALL be asynchronous and active-high.
REQ-005 Port req_valid, input, 1 bit: the requester presents a request.
REQ-006 Port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 Port req_addr, input, 32 bits: byte address.
REQ-008 Port req_wd, input, 32 bits: write data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 Port req_we, input, 1 bit: 1 means write, 0 means read.
REQ-010 Port req_dt, input, mem_dt_e: access size (MEM_DT_BYTE, MEM_DT_HALF or MEM_DT_WORD).
REQ-011 Port req_sign, input, 1 bit: 1 means sign-extend the read data, 0 means zero-extend it.
REQ-012 Port rsp_valid, output, 1 bit: a response is present.
REQ-013 Port rsp_ready, input, 1 bit: the requester consumes the response.
REQ-014 Port rsp_rd, output, 32 bits: read data, right-aligned and extended.
REQ-015 Port rsp_err_align, output, 1 bit: misaligned access or illegal req_dt.
REQ-016 Port rsp_err_range, output, 1 bit: word index is greater than or equal to N.

Function
REQ-017 The FSM SHALL have three states, IDLE, ACC and RESP; req_ready SHALL be 1 only in IDLE, and rsp_valid SHALL be 1 only in RESP.
REQ-018 In IDLE, when req_valid=1, the request SHALL be accepted on that edge: addr, wd, we, dt and sign are latched, the wait counter is loaded with WAIT, and the FSM moves to ACC.
REQ-019 In ACC, the counter SHALL decrement each cycle; on the edge where the counter equals 0, the access SHALL execute and the FSM SHALL move to RESP.
REQ-020 For an accept at edge E0, rsp_valid SHALL first be 1 after edge E0+WAIT+1.
REQ-021 In RESP, rsp_rd and both error flags SHALL be held stable until rsp_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-022 A new request SHALL be accepted no earlier than one cycle after the response handshake, so at most one request is in flight.
REQ-023 The word index SHALL be addr[31:2], and the byte lane SHALL be addr[1:0].
REQ-024 A byte write SHALL write only the selected lane from wd[7:0].
REQ-025 A half write SHALL write lanes 1:0 when addr[1]=0 and lanes 3:2 when addr[1]=1, from wd[15:0].
REQ-026 A word write SHALL write all four lanes.
REQ-027 Unselected lanes SHALL be unchanged on every write.
REQ-028 A read SHALL be captured into a register at the access edge: the selected byte or half, right-aligned, sign-extended when sign=1 and zero-extended otherwise; for a word access, sign is ignored.
REQ-029 rsp_err_align SHALL be 1 for a half access with addr[0]=1, for a word access with addr[1:0]!=0, and for any req_dt value outside the three defined values.
REQ-030 rsp_err_range SHALL be 1 when addr[31:2] >= N; both error flags may be 1 together.
REQ-031 When either error flag is 1, the memory SHALL NOT be written, and rsp_rd SHALL be 0.
REQ-032 A write response SHALL return rsp_rd=0.
REQ-033 Changes on the req_* inputs while the FSM is outside IDLE SHALL have no effect.

Reset
REQ-034 While rst=1, the FSM SHALL be IDLE, the counter 0, rsp_valid=0, rsp_rd=0, rsp_err_align=0 and rsp_err_range=0; req_ready SHALL be 1 after rst is released.
REQ-035 An assertion of rst while in ACC or RESP SHALL abort the request.
REQ-036 After such an abort, a write whose access edge has not yet occurred SHALL NOT be committed, and no response SHALL be produced.
REQ-037 Reset SHALL NOT clear memory contents.

Verification
REQ-038 With WAIT=0: word write 0x8000_00F1 at addr 0x10, then a byte read of 0x10 with sign=1 -> rsp_rd=0xFFFF_FFF1 one cycle after accept; the same read with sign=0 -> 0x0000_00F1.
REQ-039 Half write 0xBEEF at 0x16 over an existing word 0x1122_3344 at 0x14 -> a word read of 0x14 returns 0xBEEF_3344; a half read of 0x16 with sign=0 returns 0x0000_BEEF.
REQ-040 Word write at 0x22 -> rsp_err_align=1 and a subsequent word read of 0x20 shows the prior contents; write at 4*N -> rsp_err_range=1 and no word is modified.
REQ-041 With WAIT=3 and rsp_ready held at 0 for 5 cycles -> rsp_valid rises 4 cycles after accept, rsp_rd is stable for the whole stall, and req_ready=0 until the cycle after the handshake.
REQ-042 With WAIT=3: accept a write of 0xAAAA_AAAA to 0x8 over existing 0x5555_5555, then assert rst 2 cycles later -> no rsp_valid, rsp_* outputs are 0, and a read of 0x8 returns 0x5555_5555.
